grn_threshold_node: RTL and testbench
=====================================

Name: grn_threshold_node

Overview:
- Parametrised successor to the single-input boolean GRN node.
- One boolean node of a threshold-logic gene regulatory network with NUM_REG regulator inputs, split into activator and inhibitor masks, and a runtime threshold.
- Keeps a slow copy s0 (updated every SLOW_DIV-th start_s0) and a fast copy s1 (updated every start_s1) for tortoise/hare attractor detection.
- Instantiated once per gene in the generated network top; the network controller drives start_s0, start_s1 and reset_nos.

Parameters:
- NUM_REG, 4: number of regulator inputs per copy (1..16).
- SLOW_DIV, 2: slow-copy decimation; s0 updates on every SLOW_DIV-th start_s0 (1..16; 1 means every pulse).
- SCORE_W, $clog2(NUM_REG+1)+1: signed width of the score and threshold.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- reset_nos  in  1  reload both copies with init_state
- start_s0  in  1  slow-copy step strobe
- start_s1  in  1  fast-copy step strobe
- init_state  in  1  value loaded by reset_nos
- act_mask  in  NUM_REG  regulator bit i is an activator; static between reset_nos events
- inh_mask  in  NUM_REG  regulator bit i is an inhibitor; static between reset_nos events
- thr  in  SCORE_W  signed threshold; static between reset_nos events
- reg_s0  in  NUM_REG  regulator states seen by the slow copy
- reg_s1  in  NUM_REG  regulator states seen by the fast copy
- s0  out  1  slow-copy node state (registered)
- s1  out  1  fast-copy node state (registered)
- upd_s0  out  1  one-cycle pulse: s0 was written this edge
- upd_s1  out  1  one-cycle pulse: s1 was written this edge

Behaviour:
- Interface: one clock (clk). Reset rst_n is synchronous and active-low. Everything is sampled on posedge clk.
- Priority: rst_n low > reset_nos > start_s0 / start_s1. The two start strobes are independent and may assert in the same cycle.
- rst_n low: s0=0, s1=0, upd_s0=0, upd_s1=0, div_cnt=0.
- reset_nos: s0=s1=init_state, div_cnt=SLOW_DIV-1, upd_s0=upd_s1=0. This makes the first start_s0 after a reload update s0.
- Score, per copy k, combinational, signed SCORE_W:
  - score_k = popcount(reg_sk & act_mask) - popcount(reg_sk & inh_mask).
  - A bit set in both masks counts +1 and -1, net 0.
- Next state: score > thr gives 1; score < thr gives 0; score == thr holds the copy's current value (s0 for the slow copy, s1 for the fast copy).
- Slow copy, on start_s0:
  - If div_cnt == SLOW_DIV-1: s0 <= next_s0, div_cnt <= 0, upd_s0 <= 1.
  - Else: div_cnt <= div_cnt+1, s0 holds, upd_s0 <= 0.
  - With SLOW_DIV=1, div_cnt is constant 0 and every start_s0 updates s0.
- Fast copy, on start_s1: s1 <= next_s1, upd_s1 <= 1.
- upd_s0 / upd_s1 are 0 in every cycle without a qualifying update. They are high for exactly one cycle.
- Latency: reg/mask/thr to s* is one clock edge after the qualifying strobe. No combinational path from any input to any output.
- Mid-operation events:
  - rst_n low mid-run clears div_cnt; the first start_s0 after that increments div_cnt (with SLOW_DIV=2 it does not update s0).
  - reset_nos asserted together with a start strobe: the start strobe is ignored.
- div_cnt width is max(1, $clog2(SLOW_DIV)). It never exceeds SLOW_DIV-1.

Optional Feature:
- Macro GRN_NODE_MATCH_EN.
- Defined: adds output `match` (1 bit, reset 0, cleared by reset_nos).
  - Updated only in cycles where an update occurs: match <= (new s0 == new s1), using post-update values of both copies.
  - Holds otherwise.
  - The network top ANDs all nodes' match bits to detect attractor entry.
- Undefined: port and logic absent. All other behaviour identical.

Decomposition:
- Package grn_pkg holds:
  - the function popcnt(NUM_REG-bit vector);
  - localparam limits MAX_NUM_REG=16 and MAX_SLOW_DIV=16;
  - the typedef for the signed score, shared with network-level generators.
- One sub-module, grn_threshold_eval: purely combinational; inputs reg, masks, thr, cur; output next.
  - Instantiated twice, once per copy.
- Decimation counter and registers stay in the top module.

Test Plan:
- Reset: rst_n=0 for 2 cycles, all inputs random -> s0=s1=0, upd_s0=upd_s1=0.
- Threshold: NUM_REG=4, act_mask=4'b0011, inh_mask=4'b1100, thr=0.
  - reg_s1=4'b0011 + start_s1 -> s1=1, upd_s1 high 1 cycle.
  - reg_s1=4'b1101 (score -1) -> s1=0.
  - reg_s1=4'b0101 (score 0, tie) -> s1 holds 0.
- Decimation: SLOW_DIV=2, reset_nos with init_state=0, reg_s0 giving next=1, four consecutive start_s0 pulses -> s0 updates on pulses 1 and 3 only; upd_s0 pulses after pulses 1 and 3.
- Priority: reset_nos=1 with start_s0=start_s1=1, init_state=1, regulators giving next=0 -> s0=s1=1 next cycle, no upd pulse.
- Simultaneous strobes: SLOW_DIV=1, start_s0=start_s1=1, reg_s0 and reg_s1 giving opposite results -> both copies update the same edge to their own results.
- Optional (GRN_NODE_MATCH_EN): after the first decimation scenario, pulse start_s1 with next_s1=1 -> match=1; then next_s1=0 -> match=0.

Source files
------------

// File: rtl/grn_pkg.sv
// -----------------------------------------------------------------------------
// grn_pkg
// Shared definitions for the threshold-logic gene regulatory network nodes.
//   MAX_NUM_REG  : widest regulator vector a node may have
//   MAX_SLOW_DIV : largest slow-copy decimation factor
//   grn_score_t  : signed score wide enough for any legal NUM_REG, so
//                  network-level generators can share one score type
//   popcnt()     : population count of a regulator vector; narrower vectors
//                  are zero-extended to MAX_NUM_REG bits by the caller
// -----------------------------------------------------------------------------
package grn_pkg;

    localparam int MAX_NUM_REG  = 16;
    localparam int MAX_SLOW_DIV = 16;

    // Count width for 0..MAX_NUM_REG, plus one sign bit for the score.
    localparam int CNT_W        = $clog2(MAX_NUM_REG + 1);
    localparam int SCORE_MAX_W  = CNT_W + 1;

    typedef logic signed [SCORE_MAX_W-1:0] grn_score_t;

    function automatic logic [CNT_W-1:0] popcnt(input logic [MAX_NUM_REG-1:0] vec);
        logic [CNT_W-1:0] cnt;
        cnt = {CNT_W{1'b0}};
        for (int i = 0; i < MAX_NUM_REG; i++) begin
            cnt = cnt + {{(CNT_W-1){1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/grn_threshold_eval.sv
// -----------------------------------------------------------------------------
// grn_threshold_eval
// Purely combinational next-state evaluation for one copy of a threshold node.
//   reg_vec    in  NUM_REG  regulator states seen by this copy
//   act_mask   in  NUM_REG  activator mask
//   inh_mask   in  NUM_REG  inhibitor mask
//   thr        in  SCORE_W  signed threshold
//   cur        in  1        current value of this copy (kept on a tie)
//   next_state out 1        1 if score > thr, 0 if score < thr, cur if equal
// -----------------------------------------------------------------------------
module grn_threshold_eval
    import grn_pkg::*;
#(
    parameter int NUM_REG = 4,
    parameter int SCORE_W = $clog2(NUM_REG + 1) + 1
) (
    input  logic [NUM_REG-1:0]        reg_vec,
    input  logic [NUM_REG-1:0]        act_mask,
    input  logic [NUM_REG-1:0]        inh_mask,
    input  logic signed [SCORE_W-1:0] thr,
    input  logic                      cur,
    output logic                      next_state
);

    logic [MAX_NUM_REG-1:0] act_hits_s;
    logic [MAX_NUM_REG-1:0] inh_hits_s;
    grn_score_t             score_s;
    grn_score_t             thr_ext_s;

    // Score: activators present minus inhibitors present. A regulator in both
    // masks contributes +1 and -1, netting zero.
    always_comb begin
        act_hits_s                = {MAX_NUM_REG{1'b0}};
        inh_hits_s                = {MAX_NUM_REG{1'b0}};
        act_hits_s[NUM_REG-1:0]   = reg_vec & act_mask;
        inh_hits_s[NUM_REG-1:0]   = reg_vec & inh_mask;
        score_s   = $signed({1'b0, popcnt(act_hits_s)}) - $signed({1'b0, popcnt(inh_hits_s)});
        // Sign-extend the threshold to the common score width.
        thr_ext_s = grn_score_t'(thr);
    end

    // Threshold decision; equality holds the present value.
    always_comb begin
        next_state = cur;
        if (score_s > thr_ext_s) begin
            next_state = 1'b1;
        end else if (score_s < thr_ext_s) begin
            next_state = 1'b0;
        end else begin
            next_state = cur;
        end
    end

endmodule

// File: rtl/grn_threshold_node.sv
// -----------------------------------------------------------------------------
// grn_threshold_node
// One boolean gene of a threshold-logic regulatory network, kept as a slow
// copy (s0, decimated by SLOW_DIV) and a fast copy (s1) so the network can
// run tortoise/hare attractor detection.
//
// Ports:
//   clk        in   1        clock
//   rst_n      in   1        synchronous active-low reset
//   reset_nos  in   1        reload both copies with init_state
//   start_s0   in   1        slow-copy step strobe
//   start_s1   in   1        fast-copy step strobe
//   init_state in   1        value loaded by reset_nos
//   act_mask   in   NUM_REG  activator mask (static between reloads)
//   inh_mask   in   NUM_REG  inhibitor mask (static between reloads)
//   thr        in   SCORE_W  signed threshold (static between reloads)
//   reg_s0     in   NUM_REG  regulators seen by the slow copy
//   reg_s1     in   NUM_REG  regulators seen by the fast copy
//   s0, s1     out  1        registered copy states
//   upd_s0/1   out  1        one-cycle pulse: that copy was written this edge
//   match      out  1        only with GRN_NODE_MATCH_EN defined: s0 == s1
//                            after the most recent update
//
// Build option: define GRN_NODE_MATCH_EN to add the match output.
// -----------------------------------------------------------------------------
module grn_threshold_node
    import grn_pkg::*;
#(
    parameter int NUM_REG  = 4,
    parameter int SLOW_DIV = 2,
    parameter int SCORE_W  = $clog2(NUM_REG + 1) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      reset_nos,
    input  logic                      start_s0,
    input  logic                      start_s1,
    input  logic                      init_state,
    input  logic [NUM_REG-1:0]        act_mask,
    input  logic [NUM_REG-1:0]        inh_mask,
    input  logic signed [SCORE_W-1:0] thr,
    input  logic [NUM_REG-1:0]        reg_s0,
    input  logic [NUM_REG-1:0]        reg_s1,
    output logic                      s0,
    output logic                      s1,
    output logic                      upd_s0,
    output logic                      upd_s1
`ifdef GRN_NODE_MATCH_EN
    ,
    output logic                      match
`endif
);

    localparam int               DIV_W    = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SLOW_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic             s0_r;
    logic             s1_r;
    logic             upd_s0_r;
    logic             upd_s1_r;
    logic [DIV_W-1:0] div_cnt_r;
    logic             next_s0_s;
    logic             next_s1_s;
    logic             slow_fire_s;

    grn_threshold_eval #(
        .NUM_REG (NUM_REG),
        .SCORE_W (SCORE_W)
    ) u_eval_s0 (
        .reg_vec    (reg_s0),
        .act_mask   (act_mask),
        .inh_mask   (inh_mask),
        .thr        (thr),
        .cur        (s0_r),
        .next_state (next_s0_s)
    );

    grn_threshold_eval #(
        .NUM_REG (NUM_REG),
        .SCORE_W (SCORE_W)
    ) u_eval_s1 (
        .reg_vec    (reg_s1),
        .act_mask   (act_mask),
        .inh_mask   (inh_mask),
        .thr        (thr),
        .cur        (s1_r),
        .next_state (next_s1_s)
    );

    // A slow strobe only writes s0 when the decimation counter has wrapped.
    always_comb begin
        slow_fire_s = start_s0 && (div_cnt_r == DIV_LAST);
    end

    // Copy registers, decimation counter and update pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0_r      <= 1'b0;
            s1_r      <= 1'b0;
            upd_s0_r  <= 1'b0;
            upd_s1_r  <= 1'b0;
            div_cnt_r <= {DIV_W{1'b0}};
        end else if (reset_nos) begin
            // Preload the counter so the first slow strobe after a reload
            // writes s0; both copies then start in lock-step.
            s0_r      <= init_state;
            s1_r      <= init_state;
            upd_s0_r  <= 1'b0;
            upd_s1_r  <= 1'b0;
            div_cnt_r <= DIV_LAST;
        end else begin
            upd_s0_r <= 1'b0;
            upd_s1_r <= 1'b0;
            if (start_s0) begin
                if (slow_fire_s) begin
                    s0_r      <= next_s0_s;
                    div_cnt_r <= {DIV_W{1'b0}};
                    upd_s0_r  <= 1'b1;
                end else begin
                    div_cnt_r <= div_cnt_r + DIV_ONE;
                end
            end
            if (start_s1) begin
                s1_r     <= next_s1_s;
                upd_s1_r <= 1'b1;
            end
        end
    end

    assign s0     = s0_r;
    assign s1     = s1_r;
    assign upd_s0 = upd_s0_r;
    assign upd_s1 = upd_s1_r;

`ifdef GRN_NODE_MATCH_EN
    logic match_r;
    logic new_s0_s;
    logic new_s1_s;
    logic any_upd_s;

    // Post-update values of both copies, as they will be after this edge.
    always_comb begin
        new_s0_s  = slow_fire_s ? next_s0_s : s0_r;
        new_s1_s  = start_s1 ? next_s1_s : s1_r;
        any_upd_s = slow_fire_s || start_s1;
    end

    // Match flag, refreshed only on edges where a copy is written.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            match_r <= 1'b0;
        end else if (reset_nos) begin
            match_r <= 1'b0;
        end else if (any_upd_s) begin
            match_r <= (new_s0_s == new_s1_s);
        end else begin
            match_r <= match_r;
        end
    end

    assign match = match_r;
`endif

endmodule

// File: tb/tb_grn_threshold_node.sv
// -----------------------------------------------------------------------------
// tb_grn_threshold_node
// Two nodes share all inputs: dut_a with SLOW_DIV=2 and dut_b with SLOW_DIV=1.
// A reference model predicts each edge; the prediction is queued when the
// stimulus is applied and popped/compared after the edge. Scenario tasks add
// direct checks of the values the scenario is about.
// Observed/expected vectors print as {s0,s1,upd_s0,upd_s1,match}.
// -----------------------------------------------------------------------------
module tb_grn_threshold_node;

    localparam int NR = 4;
    localparam int SW = $clog2(NR + 1) + 1;

    logic clk = 1'b0;

    // 10-unit clock.
    always #5 clk = ~clk;

    logic                 rst_n, reset_nos, start_s0, start_s1, init_state;
    logic [NR-1:0]        act_mask, inh_mask, reg_s0, reg_s1;
    logic signed [SW-1:0] thr;

    logic a_s0, a_s1, a_u0, a_u1, a_m;
    logic b_s0, b_s1, b_u0, b_u1, b_m;

`ifndef GRN_NODE_MATCH_EN
    assign a_m = 1'b0;
    assign b_m = 1'b0;
`endif

    grn_threshold_node #(.NUM_REG(NR), .SLOW_DIV(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .reset_nos(reset_nos),
        .start_s0(start_s0), .start_s1(start_s1), .init_state(init_state),
        .act_mask(act_mask), .inh_mask(inh_mask), .thr(thr),
        .reg_s0(reg_s0), .reg_s1(reg_s1),
        .s0(a_s0), .s1(a_s1), .upd_s0(a_u0), .upd_s1(a_u1)
`ifdef GRN_NODE_MATCH_EN
        , .match(a_m)
`endif
    );

    grn_threshold_node #(.NUM_REG(NR), .SLOW_DIV(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .reset_nos(reset_nos),
        .start_s0(start_s0), .start_s1(start_s1), .init_state(init_state),
        .act_mask(act_mask), .inh_mask(inh_mask), .thr(thr),
        .reg_s0(reg_s0), .reg_s1(reg_s1),
        .s0(b_s0), .s1(b_s1), .upd_s0(b_u0), .upd_s1(b_u1)
`ifdef GRN_NODE_MATCH_EN
        , .match(b_m)
`endif
    );

    logic [4:0] a_obs, b_obs;
    assign a_obs = {a_s0, a_s1, a_u0, a_u1, a_m};
    assign b_obs = {b_s0, b_s1, b_u0, b_u1, b_m};

    typedef struct packed {
        logic s0; logic s1; logic u0; logic u1; logic m; int div;
    } mdl_t;

    typedef struct packed {
        logic [4:0] a;
        logic [4:0] b;
    } exp_t;

    mdl_t ma, mb;
    exp_t exp_q[$];
    exp_t e;
    int   n_run  = 0;
    int   n_fail = 0;

    // Threshold rule straight from the node definition.
    function automatic logic spec_next(input logic [NR-1:0] r, input logic cur);
        int sc;
        sc = $countones(r & act_mask) - $countones(r & inh_mask);
        if (sc > int'(thr)) return 1'b1;
        else if (sc < int'(thr)) return 1'b0;
        else return cur;
    endfunction

    // One clock edge of a node with decimation limit div_last, using the
    // inputs currently applied.
    function automatic mdl_t step(input mdl_t st, input int div_last);
        mdl_t n;
        logic ns0, ns1;
        n = st;
        if (!rst_n) begin
            n.s0 = 1'b0; n.s1 = 1'b0; n.u0 = 1'b0; n.u1 = 1'b0; n.m = 1'b0; n.div = 0;
        end else if (reset_nos) begin
            n.s0 = init_state; n.s1 = init_state;
            n.u0 = 1'b0; n.u1 = 1'b0; n.m = 1'b0; n.div = div_last;
        end else begin
            ns0 = spec_next(reg_s0, st.s0);
            ns1 = spec_next(reg_s1, st.s1);
            n.u0 = 1'b0;
            n.u1 = 1'b0;
            if (start_s0) begin
                if (st.div == div_last) begin
                    n.s0 = ns0; n.div = 0; n.u0 = 1'b1;
                end else begin
                    n.div = st.div + 1;
                end
            end
            if (start_s1) begin
                n.s1 = ns1; n.u1 = 1'b1;
            end
            if (n.u0 || n.u1) n.m = (n.s0 == n.s1);
        end
        return n;
    endfunction

    function automatic logic [4:0] pack(input mdl_t st);
`ifdef GRN_NODE_MATCH_EN
        return {st.s0, st.s1, st.u0, st.u1, st.m};
`else
        return {st.s0, st.s1, st.u0, st.u1, 1'b0};
`endif
    endfunction

    // Apply controls, queue the prediction, advance past the edge.
    task automatic drive(input logic rn, input logic nos, input logic st0, input logic st1);
        rst_n = rn; reset_nos = nos; start_s0 = st0; start_s1 = st1;
        ma = step(ma, 1);
        mb = step(mb, 0);
        exp_q.push_back('{a: pack(ma), b: pack(mb)});
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [NR-1:0] am, input logic [NR-1:0] im,
                           input logic [SW-1:0] t, input logic ini);
        act_mask = am; inh_mask = im; thr = t; init_state = ini;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            reg_s0 = 4'($urandom); reg_s1 = 4'($urandom);
            act_mask = 4'($urandom); inh_mask = 4'($urandom);
            thr = 4'($urandom); init_state = 1'($urandom);
            drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
            e = exp_q.pop_front();
            n_run++;
            if (a_obs !== 5'b00000 || b_obs !== 5'b00000) begin
                n_fail++;
                $display("FAIL reset_state cyc%0d: got A=%b B=%b want 00000", c, a_obs, b_obs);
            end
            n_run++;
            if (a_obs !== e.a) begin n_fail++; $display("FAIL reset_sb A: got %b want %b", a_obs, e.a); end
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        e = exp_q.pop_front();
        n_run++;
        if ({a_obs, b_obs} !== {e.a, e.b}) begin
            n_fail++;
            $display("FAIL reset_release: got A=%b B=%b want A=%b B=%b", a_obs, b_obs, e.a, e.b);
        end
    endtask

    typedef struct packed {
        logic [NR-1:0] am; logic [NR-1:0] im; logic [SW-1:0] t;
        logic ini; logic [NR-1:0] r; logic ex;
    } row_t;

    task automatic test_threshold();
        row_t rows[11];
        rows = '{
            '{4'b0011, 4'b1100, 4'h0, 1'b0, 4'b0011, 1'b1},  // score 2 > 0
            '{4'b0011, 4'b1100, 4'h0, 1'b1, 4'b1101, 1'b0},  // score -1 < 0
            '{4'b0011, 4'b1100, 4'h0, 1'b0, 4'b0101, 1'b0},  // tie holds 0
            '{4'b0011, 4'b1100, 4'h0, 1'b1, 4'b0101, 1'b1},  // tie holds 1
            '{4'b0011, 4'b1100, 4'hF, 1'b0, 4'b0101, 1'b1},  // 0 > -1
            '{4'b0011, 4'b1100, 4'h2, 1'b1, 4'b0011, 1'b1},  // tie at 2
            '{4'b0011, 4'b1100, 4'h2, 1'b1, 4'b0111, 1'b0},  // 1 < 2
            '{4'b0011, 4'b0110, 4'h0, 1'b1, 4'b0010, 1'b1},  // both masks: net 0
            '{4'b0011, 4'b0110, 4'h0, 1'b1, 4'b0100, 1'b0},  // -1 < 0
            '{4'b1111, 4'b0000, 4'h3, 1'b0, 4'b1111, 1'b1},  // 4 > 3
            '{4'b0000, 4'b1111, 4'hC, 1'b1, 4'b1111, 1'b1}   // tie at -4
        };
        for (int i = 0; i < 11; i++) begin
            set_cfg(rows[i].am, rows[i].im, rows[i].t, rows[i].ini);
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            e = exp_q.pop_front();
            n_run++;
            if ({a_obs, b_obs} !== {e.a, e.b}) begin
                n_fail++;
                $display("FAIL thr_reload row%0d: got A=%b B=%b want A=%b B=%b", i, a_obs, b_obs, e.a, e.b);
            end
            reg_s0 = rows[i].r; reg_s1 = rows[i].r;
            drive(1'b1, 1'b0, 1'b1, 1'b1);
            e = exp_q.pop_front();
            n_run++;
            if ({a_s0, a_s1, a_u0, a_u1} !== {rows[i].ex, rows[i].ex, 1'b1, 1'b1}) begin
                n_fail++;
                $display("FAIL thr_row%0d: got s0s1u0u1=%b%b%b%b want %b%b11", i, a_s0, a_s1, a_u0, a_u1, rows[i].ex, rows[i].ex);
            end
            n_run++;
            if ({a_obs, b_obs} !== {e.a, e.b}) begin
                n_fail++;
                $display("FAIL thr_sb row%0d: got A=%b B=%b want A=%b B=%b", i, a_obs, b_obs, e.a, e.b);
            end
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            e = exp_q.pop_front();
            n_run++;
            if (a_u0 !== 1'b0 || a_u1 !== 1'b0 || a_s1 !== rows[i].ex) begin
                n_fail++;
                $display("FAIL thr_pulse_end row%0d: got u0=%b u1=%b s1=%b want u0=0 u1=0 s1=%b", i, a_u0, a_u1, a_s1, rows[i].ex);
            end
        end
    endtask

    task automatic test_decimation();
        logic [NR-1:0] rv[4];
        logic          ex_s0[4];
        logic          ex_u0[4];
        rv    = '{4'b0011, 4'b1100, 4'b1100, 4'b0011};
        ex_s0 = '{1'b1, 1'b1, 1'b0, 1'b0};
        ex_u0 = '{1'b1, 1'b0, 1'b1, 1'b0};
        set_cfg(4'b0011, 4'b1100, 4'h0, 1'b0);
        reg_s1 = 4'b0000;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        e = exp_q.pop_front();
        for (int p = 0; p < 4; p++) begin
            reg_s0 = rv[p];
            drive(1'b1, 1'b0, 1'b1, 1'b0);
            e = exp_q.pop_front();
            n_run++;
            if (a_s0 !== ex_s0[p] || a_u0 !== ex_u0[p]) begin
                n_fail++;
                $display("FAIL decim_pulse%0d: got s0=%b upd_s0=%b want s0=%b upd_s0=%b", p + 1, a_s0, a_u0, ex_s0[p], ex_u0[p]);
            end
            n_run++;
            if ({a_obs, b_obs} !== {e.a, e.b}) begin
                n_fail++;
                $display("FAIL decim_sb%0d: got A=%b B=%b want A=%b B=%b", p + 1, a_obs, b_obs, e.a, e.b);
            end
        end
        // Reset mid-run: the counter restarts at 0, so one pulse is skipped.
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        e = exp_q.pop_front();
        reg_s0 = 4'b0011;
        for (int p = 0; p < 2; p++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0);
            e = exp_q.pop_front();
            n_run++;
            if (a_s0 !== 1'(p) || a_u0 !== 1'(p)) begin
                n_fail++;
                $display("FAIL decim_after_rst%0d: got s0=%b upd_s0=%b want %0d/%0d", p + 1, a_s0, a_u0, p, p);
            end
            n_run++;
            if ({a_obs, b_obs} !== {e.a, e.b}) begin
                n_fail++;
                $display("FAIL decim_rst_sb%0d: got A=%b B=%b want A=%b B=%b", p + 1, a_obs, b_obs, e.a, e.b);
            end
        end
`ifdef GRN_NODE_MATCH_EN
        // s0 is 1 here; drive s1 to 1 then 0.
        reg_s1 = 4'b0011;
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        e = exp_q.pop_front();
        n_run++;
        if (a_m !== 1'b1) begin n_fail++; $display("FAIL match_set: got %b want 1", a_m); end
        reg_s1 = 4'b1100;
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        e = exp_q.pop_front();
        n_run++;
        if (a_m !== 1'b0) begin n_fail++; $display("FAIL match_clr: got %b want 0", a_m); end
        n_run++;
        if ({a_obs, b_obs} !== {e.a, e.b}) begin
            n_fail++;
            $display("FAIL match_sb: got A=%b B=%b want A=%b B=%b", a_obs, b_obs, e.a, e.b);
        end
`endif
    endtask

    task automatic test_priority();
        set_cfg(4'b0011, 4'b1100, 4'h0, 1'b1);
        reg_s0 = 4'b1100; reg_s1 = 4'b1100;
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        e = exp_q.pop_front();
        n_run++;
        if (a_obs[4:1] !== 4'b1100 || b_obs[4:1] !== 4'b1100) begin
            n_fail++;
            $display("FAIL prio_reload: got A=%b B=%b want s0s1u0u1=1100", a_obs, b_obs);
        end
        // First slow strobe after a reload writes s0 even with SLOW_DIV=2.
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        e = exp_q.pop_front();
        n_run++;
        if (a_s0 !== 1'b0 || a_u0 !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_first_s0: got s0=%b upd_s0=%b want s0=0 upd_s0=1", a_s0, a_u0);
        end
        n_run++;
        if ({a_obs, b_obs} !== {e.a, e.b}) begin
            n_fail++;
            $display("FAIL prio_sb: got A=%b B=%b want A=%b B=%b", a_obs, b_obs, e.a, e.b);
        end
    endtask

    task automatic test_simultaneous();
        set_cfg(4'b0011, 4'b1100, 4'h0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        e = exp_q.pop_front();
        reg_s1 = 4'b0011;
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        e = exp_q.pop_front();
        reg_s0 = 4'b0011; reg_s1 = 4'b1100;
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        e = exp_q.pop_front();
        n_run++;
        if (b_obs[4:1] !== 4'b1011) begin
            n_fail++;
            $display("FAIL simul_b: got s0s1u0u1=%b want 1011", b_obs[4:1]);
        end
        n_run++;
        if ({a_obs, b_obs} !== {e.a, e.b}) begin
            n_fail++;
            $display("FAIL simul_sb: got A=%b B=%b want A=%b B=%b", a_obs, b_obs, e.a, e.b);
        end
    endtask

    task automatic test_back_to_back();
        logic rn, nos;
        for (int c = 0; c < 80; c++) begin
            rn  = ($urandom_range(0, 24) != 0);
            nos = ($urandom_range(0, 7) == 0);
            if (nos) begin
                set_cfg(4'($urandom), 4'($urandom), 4'($urandom_range(0, 15)), 1'($urandom));
            end
            reg_s0 = 4'($urandom); reg_s1 = 4'($urandom);
            drive(rn, nos, 1'($urandom), 1'($urandom));
            e = exp_q.pop_front();
            n_run++;
            if (a_obs !== e.a) begin n_fail++; $display("FAIL b2b_a cyc%0d: got %b want %b", c, a_obs, e.a); end
            n_run++;
            if (b_obs !== e.b) begin n_fail++; $display("FAIL b2b_b cyc%0d: got %b want %b", c, b_obs, e.b); end
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        rst_n = 1'b0; reset_nos = 1'b0; start_s0 = 1'b0; start_s1 = 1'b0;
        init_state = 1'b0; act_mask = 4'b0000; inh_mask = 4'b0000;
        thr = 4'sd0; reg_s0 = 4'b0000; reg_s1 = 4'b0000;
        ma = '0; mb = '0;
        #1;
        test_reset();
        test_threshold();
        test_decimation();
        test_priority();
        test_simultaneous();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
